musicbox_sdram_arbiter: RTL



---
 rtl/musicbox_sdram_arbiter_if.sv | 38 +++
 rtl/musicbox_sdram_arbiter.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/musicbox_sdram_arbiter_if.sv
// Bus bundle between the MusicBox datapaths, the SDRAM arbiter and the SDRAM controller.
// The slave modport is the arbiter's view. The master modport is the view from the surrounding system.
interface musicbox_sdram_arbiter_if #(
    parameter int NUM_REQ = 3,
    parameter int ADDR_W  = 25,
    parameter int DATA_W  = 16
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_write;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_wdata;
    logic [NUM_REQ-1:0]        req_accept;
    logic [NUM_REQ-1:0]        rsp_valid;
    logic [DATA_W-1:0]         rsp_data;
    logic                      rsp_error;
    logic                      mem_cmd_valid;
    logic                      mem_cmd_ready;
    logic                      mem_cmd_write;
    logic [ADDR_W-1:0]         mem_cmd_addr;
    logic [DATA_W-1:0]         mem_cmd_wdata;
    logic                      mem_rd_valid;
    logic [DATA_W-1:0]         mem_rd_data;
    logic                      busy;

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata,
        input  mem_cmd_ready, mem_rd_valid, mem_rd_data,
        output req_accept, rsp_valid, rsp_data, rsp_error,
        output mem_cmd_valid, mem_cmd_write, mem_cmd_addr, mem_cmd_wdata, busy
    );

    modport master (
        output req_valid, req_write, req_addr, req_wdata,
        output mem_cmd_ready, mem_rd_valid, mem_rd_data,
        input  req_accept, rsp_valid, rsp_data, rsp_error,
        input  mem_cmd_valid, mem_cmd_write, mem_cmd_addr, mem_cmd_wdata, busy
    );
endinterface

// File: rtl/musicbox_sdram_arbiter.sv
// Round-robin arbiter for the single SDRAM command port shared by the MusicBox recorder/player datapaths.
// Only one transaction is in flight at a time. A read that gets no data back within RD_TIMEOUT cycles completes with an error.
module musicbox_sdram_arbiter #(
    parameter int NUM_REQ    = 3,
    parameter int ADDR_W     = 25,
    parameter int DATA_W     = 16,
    parameter int RD_TIMEOUT = 255
) (
    input  logic                    clock_50Mhz,
    input  logic                    reset,
    musicbox_sdram_arbiter_if.slave bus
);
    localparam int GRANT_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_RD
    } arbState_t;

    arbState_t          state, nextState;
    logic [GRANT_W-1:0] lastGrant, nextLastGrant;
    logic [GRANT_W-1:0] grant, nextGrant;
    logic [GRANT_W-1:0] pick;
    logic               cmdValid, nextCmdValid;
    logic               cmdWrite, nextCmdWrite;
    logic [ADDR_W-1:0]  cmdAddr, nextCmdAddr;
    logic [DATA_W-1:0]  cmdWdata, nextCmdWdata;
    logic [NUM_REQ-1:0] rspValid, nextRspValid;
    logic [DATA_W-1:0]  rspData, nextRspData;
    logic               rspError, nextRspError;
    logic [15:0]        rdCount, nextRdCount;
    logic [NUM_REQ-1:0] grantOneHot;
    logic               handshake;

    // Scan upward from the requester after the last one served, wrapping, so nobody starves.
    always_comb begin
        logic               found;
        int                 idx;
        logic [GRANT_W-1:0] cand;
        pick  = lastGrant;
        found = 1'b0;
        idx   = 0;
        cand  = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = int'(lastGrant) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            cand = GRANT_W'(idx);
            if (!found && bus.req_valid[cand]) begin
                pick  = cand;
                found = 1'b1;
            end
        end
    end

    assign grantOneHot = NUM_REQ'(1) << grant;
    assign handshake   = (state == ISSUE) && bus.mem_cmd_ready;

    // Next-state and next-register values. The command fields are latched at grant time, so the requester may change its inputs freely afterwards.
    always_comb begin
        nextState     = state;
        nextLastGrant = lastGrant;
        nextGrant     = grant;
        nextCmdValid  = cmdValid;
        nextCmdWrite  = cmdWrite;
        nextCmdAddr   = cmdAddr;
        nextCmdWdata  = cmdWdata;
        nextRspValid  = '0;
        nextRspData   = rspData;
        nextRspError  = rspError;
        nextRdCount   = rdCount;
        unique case (state)
            IDLE: begin
                if (|bus.req_valid) begin
                    nextGrant    = pick;
                    nextCmdWrite = bus.req_write[pick];
                    nextCmdAddr  = bus.req_addr[int'(pick)*ADDR_W +: ADDR_W];
                    nextCmdWdata = bus.req_wdata[int'(pick)*DATA_W +: DATA_W];
                    nextCmdValid = 1'b1;
                    nextState    = ISSUE;
                end
            end
            ISSUE: begin
                if (handshake) begin
                    nextLastGrant = grant;
                    nextCmdValid  = 1'b0;
                    if (cmdWrite) begin
                        nextState = IDLE;
                    end else begin
                        nextState   = WAIT_RD;
                        nextRdCount = '0;
                    end
                end
            end
            WAIT_RD: begin
                // If data and timeout land in the same cycle, the data wins.
                if (bus.mem_rd_valid) begin
                    nextRspValid = grantOneHot;
                    nextRspData  = bus.mem_rd_data;
                    nextRspError = 1'b0;
                    nextState    = IDLE;
                end else if (rdCount == 16'(RD_TIMEOUT - 1)) begin
                    nextRspValid = grantOneHot;
                    nextRspData  = '0;
                    nextRspError = 1'b1;
                    nextState    = IDLE;
                end else begin
                    nextRdCount = rdCount + 16'd1;
                end
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

    // State register. A reset abandons any in-flight command without a response.
    always_ff @(posedge clock_50Mhz) begin
        if (reset) begin
            state     <= IDLE;
            lastGrant <= GRANT_W'(NUM_REQ - 1);
            grant     <= '0;
            cmdValid  <= 1'b0;
            cmdWrite  <= 1'b0;
            cmdAddr   <= '0;
            cmdWdata  <= '0;
            rspValid  <= '0;
            rspData   <= '0;
            rspError  <= 1'b0;
            rdCount   <= '0;
        end else begin
            state     <= nextState;
            lastGrant <= nextLastGrant;
            grant     <= nextGrant;
            cmdValid  <= nextCmdValid;
            cmdWrite  <= nextCmdWrite;
            cmdAddr   <= nextCmdAddr;
            cmdWdata  <= nextCmdWdata;
            rspValid  <= nextRspValid;
            rspData   <= nextRspData;
            rspError  <= nextRspError;
            rdCount   <= nextRdCount;
        end
    end

    assign bus.req_accept    = handshake ? grantOneHot : '0;
    assign bus.rsp_valid     = rspValid;
    assign bus.rsp_data      = rspData;
    assign bus.rsp_error     = rspError;
    assign bus.mem_cmd_valid = cmdValid;
    assign bus.mem_cmd_write = cmdWrite;
    assign bus.mem_cmd_addr  = cmdAddr;
    assign bus.mem_cmd_wdata = cmdWdata;
    assign bus.busy          = (state != IDLE);
endmodule
